// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues synchronous imem reads and buffers {pc, instr} pairs for decode.
// Optional feature macro: IF_MISALIGN_CHK_EN (misaligned redirect raises sticky fetch_fault and halts fetch).
module instr_fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               id_ready,
    output logic               fetch_fault
);

    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic               inflight_r;
    logic               drop_r;
    logic               fault_r;
    logic [ADDR_W-1:0]  fifo_pc_r    [2];
    logic [INSTR_W-1:0] fifo_instr_r [2];
    logic               rd_ptr_r;
    logic               wr_ptr_r;
    logic [1:0]         count_r;

    logic               pop_s;
    logic               push_s;
    logic               issue_s;
    logic               fault_halt_s;
    logic               misalign_s;
    logic [ADDR_W-1:0]  target_s;
    logic [2:0]         credit_s;

    // Redirect target conditioning and misalignment detection
    always_comb begin
        target_s     = br_target;
        misalign_s   = 1'b0;
        fault_halt_s = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        misalign_s   = (br_target[1:0] != 2'b00);
        fault_halt_s = fault_r;
`else
        target_s     = br_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};
`endif
    end

    // Handshake, credit-based issue and response capture decisions
    always_comb begin
        pop_s    = (count_r != 2'd0) & id_ready & ~br_taken;
        // Entries already buffered plus the read in flight must leave room for the new read.
        credit_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s  = reset & ~br_taken & ~fault_halt_s & (credit_s < 3'd2);
        push_s   = inflight_r & ~drop_r & ~br_taken;
    end

    // Output drive: head of the buffer, zeroed while empty
    always_comb begin
        imem_rd_en  = issue_s;
        imem_addr   = pc_r;
        if_valid    = (count_r != 2'd0);
        fetch_fault = fault_r;
        if (count_r != 2'd0) begin
            if_pc    = fifo_pc_r[rd_ptr_r];
            if_instr = fifo_instr_r[rd_ptr_r];
        end else begin
            if_pc    = {ADDR_W{1'b0}};
            if_instr = {INSTR_W{1'b0}};
        end
    end

    // Program counter, outstanding-read tracking and sticky fault
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            drop_r        <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            if (br_taken) begin
                pc_r <= target_s;
            end else if (issue_s) begin
                pc_r <= pc_r + ADDR_W'(4);
            end
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end
            // A read launched alongside a redirect is wrong-path; the issue rule keeps this empty.
            drop_r <= issue_s & br_taken;
            if (br_taken & misalign_s) begin
                fault_r <= 1'b1;
            end
        end
    end

    // Two-entry {pc, instr} buffer; a redirect flushes it and overrides any pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc_r[i]    <= {ADDR_W{1'b0}};
                fifo_instr_r[i] <= {INSTR_W{1'b0}};
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (br_taken) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
                fifo_instr_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r               <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

endmodule
